keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Input-side stage that drives the 4x3 matrix keypad. It scans the rows, synchronises and debounces the column returns, and encodes the pressed key into a 4-bit code. It presents that code with a data-available indication to the traffic-controller system block. It replaces the scan/debounce part of the input stage and runs entirely in the 50 MHz board clock domain.

Parameters:
SCAN_DIV, 100000, board-clock cycles per scan tick (50 MHz / 500 Hz); minimum 2.
DEBOUNCE_TICKS, 4, consecutive identical scan-tick samples required to confirm a press or a release; minimum 1.

Ports:
clock  input  1  board clock, 50 MHz.
reset  input  1  asynchronous, active-low reset.
col  input  3  keypad column returns, pulled up; low = key closed; asynchronous to clock.
row  output  4  row drive, active-low, one-hot-low while scanning.
key_data  output  4  code of the confirmed key.
dav  output  1  level; high from press confirmation until release confirmation.
key_strobe  output  1  one-clock pulse on press confirmation.

Behaviour:
- Reset values: row=4'b1110, key_data=4'h0, dav=0, key_strobe=0, FSM=SCAN, all counters 0, synchroniser flops=3'b111.
- Reset is asynchronous, active-low. Assertion at any point aborts the current operation immediately. A key held through reset is re-detected normally after release of reset.
- col passes through a 2-flop synchroniser; all decisions use the synchronised value col_s.
- Tick generator: a free-running counter wraps at SCAN_DIV-1; tick=1 for one clock at wrap. All FSM activity below happens only on tick cycles, except key_strobe clearing.
- Key map (row index r = position of the low bit, col index c with col[0]=left):
  - r0: 1,2,3
  - r1: 4,5,6
  - r2: 7,8,9
  - r3: *=4'hA, 0=4'h0, #=4'hB
- Valid press: exactly one bit of col_s is low. Zero or multiple low bits count as "no key".
- FSM states:
  - SCAN: on tick, if valid press, latch r/c candidate, deb_cnt=1, go to DEBOUNCE (row frozen). Otherwise rotate row (1110→1101→1011→0111→1110).
  - DEBOUNCE: on tick, if col_s equals the latched candidate pattern, deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS: key_data=encoded code, dav=1, key_strobe=1 for one clock, go to HELD. If the pattern differs: deb_cnt=0, go to SCAN, row advances on the next tick.
  - HELD: row stays frozen. On tick, if col_s==3'b111, deb_cnt=1, go to RELEASE. Any other pattern, including a second key, is ignored.
  - RELEASE: on tick, if col_s==111, deb_cnt++; at DEBOUNCE_TICKS, dav=0, go to SCAN. If not 111, deb_cnt=0, return to HELD (bounce).
- Latency: confirmation occurs on the DEBOUNCE_TICKS-th consecutive qualifying tick, counting the detecting tick, plus 2-clock synchroniser delay.
- key_data keeps its last value after release and updates only on press confirmation.
- No key repeat: one key_strobe per press regardless of hold time.
- Consumers in slower clock domains sample dav as a level. dav is held for at least DEBOUNCE_TICKS scan ticks.

Decomposition:
- Shared package: state enum (SCAN, DEBOUNCE, HELD, RELEASE), codes KEY_STAR=4'hA and KEY_HASH=4'hB, reset row value 4'b1110.
- One sub-module: keypad_encoder, combinational {row index, col_s} → {valid, 4-bit code}, reused by DEBOUNCE confirmation.
- Synchroniser and tick divider stay inline.

Test Plan:
Use SCAN_DIV=4 and DEBOUNCE_TICKS=3 for all scenarios.
- Reset: hold reset=0, col=111 → row=1110, dav=0, key_strobe=0, key_data=0. After release, row rotates every 4 clocks.
- Clean press of key 5 (col=101 while row=1101, held 10 ticks) → row freezes at 1101, key_data=4'h5, single key_strobe pulse, dav=1. After col=111 for 3 ticks, dav=0 and scanning resumes.
- Bounce: press # (row 0111, col 011) toggling to 111 every other tick for 6 ticks, then stable → no strobe during bounce; exactly one strobe with key_data=4'hB once stable.
- Two keys in the same row (col=001 on row 1110) → treated as no key; no dav; row keeps rotating.
- Hold key 1 for 50 ticks, then press 3 additionally while held → exactly one strobe, key_data=4'h1, dav stays 1 until all released for 3 ticks.
- Reset mid-HELD (dav=1, key 0 held) → dav=0 and row=1110 immediately, asynchronously. After reset release with the key still held, key 0 is re-confirmed and key_data=4'h0 with one strobe.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x3 keypad scanner.
// Pure declarations: no latency, no flow control.
package keypad_scanner_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam logic [3:0] KEY_STAR  = 4'hA;
   localparam logic [3:0] KEY_HASH  = 4'hB;
   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Position of the driven (low) row; a malformed row pattern maps to row 0.
   function automatic logic [1:0] row_index(input logic [3:0] row_pat);
      logic [1:0] idx;
      idx = 2'd0;
      if (!row_pat[0])      idx = 2'd0;
      else if (!row_pat[1]) idx = 2'd1;
      else if (!row_pat[2]) idx = 2'd2;
      else if (!row_pat[3]) idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_encoder.sv
// Combinational {row index, column pattern} -> {valid, key code}; zero latency.
// Valid only when exactly one column is low; no flow control.
module keypad_encoder
   import keypad_scanner_pkg::*;
(
   input  logic [1:0] row_idx,
   input  logic [2:0] col_pat,
   output logic       valid,
   output logic [3:0] code
);

   logic [1:0] col_idx;

   always_comb begin
      valid   = 1'b0;
      col_idx = 2'd0;
      case (col_pat)
         3'b110:  begin valid = 1'b1; col_idx = 2'd0; end
         3'b101:  begin valid = 1'b1; col_idx = 2'd1; end
         3'b011:  begin valid = 1'b1; col_idx = 2'd2; end
         default: begin valid = 1'b0; col_idx = 2'd0; end
      endcase
   end

   always_comb begin
      code = 4'h0;
      if (row_idx == 2'd3) begin
         case (col_idx)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'h0;
            default: code = KEY_HASH;
         endcase
      end else begin
         // digit rows: 3*r + c + 1
         code = ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx} + 4'd1;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x3 keypad, debounces press/release over scan ticks, emits code + dav level + strobe.
// Press confirmed on the DEBOUNCE_TICKS-th qualifying tick after a 2-clock sync; no backpressure.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_TICKS = 4
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] col,
   output logic [3:0] row,
   output logic [3:0] key_data,
   output logic       dav,
   output logic       key_strobe
);

   localparam int DIVW = $clog2(SCAN_DIV);
   localparam int DEBW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
   localparam logic [DEBW-1:0] DEB_DONE = DEBW'(DEBOUNCE_TICKS);
   localparam logic [DEBW-1:0] DEB_ONE  = DEBW'(1);

   logic [2:0]      col_m_q,      col_m_d;
   logic [2:0]      col_s_q,      col_s_d;
   logic [DIVW-1:0] div_q,        div_d;
   state_t          state_q,      state_d;
   logic [3:0]      row_q,        row_d;
   logic [DEBW-1:0] deb_q,        deb_d;
   logic [1:0]      cand_row_q,   cand_row_d;
   logic [2:0]      cand_col_q,   cand_col_d;
   logic [3:0]      key_data_q,   key_data_d;
   logic            dav_q,        dav_d;
   logic            strobe_q,     strobe_d;

   logic            tick;
   logic [DEBW-1:0] deb_inc;
   logic [1:0]      enc_row;
   logic [2:0]      enc_col;
   logic            enc_valid;
   logic [3:0]      enc_code;

   // While scanning, qualify the live sample; afterwards encode the latched candidate.
   assign enc_row = (state_q == SCAN) ? row_index(row_q) : cand_row_q;
   assign enc_col = (state_q == SCAN) ? col_s_q : cand_col_q;

   keypad_encoder u_encoder (
      .row_idx (enc_row),
      .col_pat (enc_col),
      .valid   (enc_valid),
      .code    (enc_code)
   );

   always_comb begin
      col_m_d    = col;
      col_s_d    = col_m_q;
      tick       = (div_q == DIV_LAST);
      div_d      = tick ? '0 : div_q + 1'b1;
      deb_inc    = deb_q + DEB_ONE;
      state_d    = state_q;
      row_d      = row_q;
      deb_d      = deb_q;
      cand_row_d = cand_row_q;
      cand_col_d = cand_col_q;
      key_data_d = key_data_q;
      dav_d      = dav_q;
      strobe_d   = 1'b0;

      case (state_q)
         SCAN: begin
            if (tick) begin
               if (enc_valid) begin
                  cand_row_d = row_index(row_q);
                  cand_col_d = col_s_q;
                  if (DEBOUNCE_TICKS == 1) begin
                     key_data_d = enc_code;
                     dav_d      = 1'b1;
                     strobe_d   = 1'b1;
                     deb_d      = '0;
                     state_d    = HELD;
                  end else begin
                     deb_d   = DEB_ONE;
                     state_d = DEBOUNCE;
                  end
               end else begin
                  row_d = {row_q[2:0], row_q[3]};
               end
            end
         end

         DEBOUNCE: begin
            if (tick) begin
               if (col_s_q == cand_col_q) begin
                  if (deb_inc == DEB_DONE) begin
                     key_data_d = enc_code;
                     dav_d      = 1'b1;
                     strobe_d   = 1'b1;
                     deb_d      = '0;
                     state_d    = HELD;
                  end else begin
                     deb_d = deb_inc;
                  end
               end else begin
                  deb_d   = '0;
                  state_d = SCAN;
               end
            end
         end

         HELD: begin
            if (tick && (col_s_q == 3'b111)) begin
               if (DEBOUNCE_TICKS == 1) begin
                  dav_d   = 1'b0;
                  deb_d   = '0;
                  state_d = SCAN;
               end else begin
                  deb_d   = DEB_ONE;
                  state_d = RELEASE;
               end
            end
         end

         RELEASE: begin
            if (tick) begin
               if (col_s_q == 3'b111) begin
                  if (deb_inc == DEB_DONE) begin
                     dav_d   = 1'b0;
                     deb_d   = '0;
                     state_d = SCAN;
                  end else begin
                     deb_d = deb_inc;
                  end
               end else begin
                  deb_d   = '0;
                  state_d = HELD;
               end
            end
         end

         default: begin
            deb_d   = '0;
            state_d = SCAN;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_m_q    <= 3'b111;
         col_s_q    <= 3'b111;
         div_q      <= '0;
         state_q    <= SCAN;
         row_q      <= ROW_RESET;
         deb_q      <= '0;
         cand_row_q <= 2'd0;
         cand_col_q <= 3'b111;
         key_data_q <= 4'h0;
         dav_q      <= 1'b0;
         strobe_q   <= 1'b0;
      end else begin
         col_m_q    <= col_m_d;
         col_s_q    <= col_s_d;
         div_q      <= div_d;
         state_q    <= state_d;
         row_q      <= row_d;
         deb_q      <= deb_d;
         cand_row_q <= cand_row_d;
         cand_col_q <= cand_col_d;
         key_data_q <= key_data_d;
         dav_q      <= dav_d;
         strobe_q   <= strobe_d;
      end
   end

   assign row        = row_q;
   assign key_data   = key_data_q;
   assign dav        = dav_q;
   assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x3 key matrix (SCAN_DIV=4, DEBOUNCE_TICKS=3).
// Times below are in clocks relative to a tick edge; ticks land every 4 clocks.
module tb_keypad_scanner;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  col;
   logic [3:0]  row;
   logic [3:0]  key_data;
   logic        dav;
   logic        key_strobe;
   logic [11:0] pressed;

   int compared   = 0;
   int mismatched = 0;
   int strobes    = 0;
   int s0;

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_TICKS (3)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .col        (col),
      .row        (row),
      .key_data   (key_data),
      .dav        (dav),
      .key_strobe (key_strobe)
   );

   always #5 clock = ~clock;

   // Key matrix: a pressed key at (r,c) pulls col[c] low while row[r] is driven low.
   always_comb begin
      col = 3'b111;
      for (int r = 0; r < 4; r++)
         if (!row[r])
            for (int c = 0; c < 3; c++)
               if (pressed[r*3+c]) col[c] = 1'b0;
   end

   always @(negedge clock) if (key_strobe === 1'b1) strobes++;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Returns on the negedge just after row switches to target (a tick edge).
   task automatic wait_row(input logic [3:0] target, input string tag);
      logic [3:0] prev;
      bit found;
      found = 1'b0;
      prev  = row;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clock);
         if (row === target && prev !== target) found = 1'b1;
         prev = row;
      end
      chk(tag, 8'(found), 8'd1);
   endtask

   initial begin
      reset   = 1'b0;
      pressed = '0;
      cyc(3);
      chk("rst_row",    8'(row),        8'h0E);
      chk("rst_dav",    8'(dav),        8'h00);
      chk("rst_strobe", 8'(key_strobe), 8'h00);
      chk("rst_key",    8'(key_data),   8'h00);

      reset = 1'b1;
      cyc(3);
      chk("scan_row_hold", 8'(row), 8'h0E);
      cyc(1);
      chk("scan_row_rot",  8'(row), 8'h0D);

      // Key 5 pressed on the tick edge that drives row 1101: detect +4, confirm +12.
      s0 = strobes;
      pressed[4] = 1'b1;
      cyc(11);
      chk("k5_pre_dav",   8'(dav), 8'h00);
      chk("k5_frozen",    8'(row), 8'h0D);
      cyc(1);
      chk("k5_strobe",    8'(key_strobe), 8'h01);
      chk("k5_data",      8'(key_data),   8'h05);
      chk("k5_dav",       8'(dav),        8'h01);
      cyc(1);
      chk("k5_strobe_clr", 8'(key_strobe), 8'h00);
      cyc(39);
      chk("k5_single",    8'(strobes - s0), 8'h01);
      chk("k5_hold_row",  8'(row),          8'h0D);
      pressed[4] = 1'b0;
      cyc(11);
      chk("k5_rel_pre",   8'(dav), 8'h01);
      cyc(1);
      chk("k5_rel_dav",   8'(dav), 8'h00);
      cyc(4);
      chk("k5_resume",    8'(row),      8'h0B);
      chk("k5_keep_data", 8'(key_data), 8'h05);

      // Keys 2 and 3 together: col=001 on row 1110 is not a key.
      s0 = strobes;
      pressed[1] = 1'b1;
      pressed[2] = 1'b1;
      cyc(8);
      chk("two_row0", 8'(row), 8'h0E);
      chk("two_dav",  8'(dav), 8'h00);
      cyc(4);
      chk("two_rot",  8'(row), 8'h0D);
      chk("two_nostrobe", 8'(strobes - s0), 8'h00);
      pressed = '0;

      // '#' bouncing for 6 ticks then stable: confirm 12 clocks after it settles.
      wait_row(4'b0111, "wait_hash");
      s0 = strobes;
      for (int i = 0; i < 6; i++) begin
         pressed[11] = (i % 2 == 0);
         cyc(4);
      end
      pressed[11] = 1'b1;
      cyc(11);
      chk("hash_no_strobe", 8'(strobes - s0), 8'h00);
      chk("hash_row",       8'(row),          8'h07);
      cyc(1);
      chk("hash_strobe", 8'(key_strobe), 8'h01);
      chk("hash_data",   8'(key_data),   8'h0B);
      pressed[11] = 1'b0;
      cyc(11);
      chk("hash_rel_pre", 8'(dav), 8'h01);
      cyc(1);
      chk("hash_rel_dav", 8'(dav), 8'h00);
      chk("hash_single",  8'(strobes - s0), 8'h01);

      // Key 1 held 50 ticks, then key 3 added in the same row.
      wait_row(4'b1110, "wait_k1");
      s0 = strobes;
      pressed[0] = 1'b1;
      cyc(12);
      chk("k1_strobe", 8'(key_strobe), 8'h01);
      chk("k1_data",   8'(key_data),   8'h01);
      cyc(200);
      pressed[2] = 1'b1;
      cyc(40);
      chk("k1_dav_held", 8'(dav),          8'h01);
      chk("k1_data_kept", 8'(key_data),    8'h01);
      chk("k1_single",   8'(strobes - s0), 8'h01);
      chk("k1_row",      8'(row),          8'h0E);
      pressed = '0;
      cyc(11);
      chk("k1_rel_pre", 8'(dav), 8'h01);
      cyc(1);
      chk("k1_rel_dav", 8'(dav), 8'h00);

      // Key 0 confirmed, then reset while held, then re-detected after reset.
      wait_row(4'b0111, "wait_k0");
      s0 = strobes;
      pressed[10] = 1'b1;
      cyc(12);
      chk("k0_dav",  8'(dav),      8'h01);
      chk("k0_data", 8'(key_data), 8'h00);
      cyc(8);
      reset = 1'b0;
      #1;
      chk("arst_dav",    8'(dav),        8'h00);
      chk("arst_row",    8'(row),        8'h0E);
      chk("arst_strobe", 8'(key_strobe), 8'h00);
      cyc(3);
      reset = 1'b1;
      cyc(23);
      chk("redet_pre_dav", 8'(dav),          8'h00);
      chk("redet_pre_cnt", 8'(strobes - s0), 8'h01);
      cyc(1);
      chk("redet_strobe", 8'(key_strobe), 8'h01);
      chk("redet_data",   8'(key_data),   8'h00);
      chk("redet_dav",    8'(dav),        8'h01);
      chk("redet_row",    8'(row),        8'h07);
      pressed = '0;
      cyc(20);
      chk("redet_total", 8'(strobes - s0), 8'h02);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
